// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame geometry, command layout and FSM states.
// SPI mode 3 throughout: SCK idles high, data sampled on the rising edge, shifted on the falling edge.
package spi_pkg;

    localparam int DATA_BYTES = 6;
    localparam int ADDR_W     = 7;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pin bundle between a master and the responder.
interface spi_responder_if;

    logic sck;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sck, output cs, output mosi, input miso);
    modport slave  (input sck, input cs, input mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rise/fall pulses taken from
// the synchronised level against one further delayed copy.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic stage1;
    logic stage2;
    logic stage3;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= RESET_VAL;
            stage2 <= RESET_VAL;
            stage3 <= RESET_VAL;
        end else begin
            stage1 <= raw;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign level = stage2;
    assign rise  = stage2 & ~stage3;
    assign fall  = ~stage2 & stage3;

endmodule

// File: rtl/spi_responder.sv
// Mode-3 SPI slave running on the system clock: decodes {R/W, addr} commands, streams a
// snapshot of sample_in on reads and emits address-tagged byte strobes on writes.
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA_BYTES = spi_pkg::DATA_BYTES,
    parameter int ADDR_W     = spi_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_responder_if.slave          spi,
    input  logic [8*DATA_BYTES-1:0] sample_in,
    output logic                    rd_strobe,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic                    wr_valid,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int DATA_BITS = 8 * DATA_BYTES;
    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_RD_CNT = BIT_CNT_W'(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BYTE_LAST   = BIT_CNT_W'(7);

    logic unused_sck_level;
    logic sck_rise;
    logic sck_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic [1:0] mosi_meta;
    logic mosi_bit;

    state_t                 state,    state_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt,  bit_cnt_nxt;
    logic [7:0]             rx_shift, rx_shift_nxt;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
    logic [ADDR_W-1:0]      byte_idx, byte_idx_nxt;
    logic                   armed,    armed_nxt;
    logic                   miso_q,   miso_nxt;
    logic                   rd_strobe_nxt;
    logic                   wr_valid_nxt;
    logic                   frame_err_nxt;
    logic [ADDR_W-1:0]      cmd_addr_nxt;
    logic [ADDR_W-1:0]      wr_addr_nxt;
    logic [7:0]             wr_data_nxt;
    logic [7:0]             rx_word;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (spi.sck),
        .level (unused_sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // cs resets low so a frame already in progress at reset release never looks armed.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (spi.cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta <= 2'b11;
        end else begin
            mosi_meta <= {mosi_meta[0], spi.mosi};
        end
    end

    assign mosi_bit = mosi_meta[1];
    assign rx_word  = {rx_shift[6:0], mosi_bit};
    assign spi.miso = miso_q;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            byte_idx  <= '0;
            armed     <= 1'b0;
            miso_q    <= 1'b1;
            rd_strobe <= 1'b0;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_addr  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_shift  <= rx_shift_nxt;
            tx_shift  <= tx_shift_nxt;
            byte_idx  <= byte_idx_nxt;
            armed     <= armed_nxt;
            miso_q    <= miso_nxt;
            rd_strobe <= rd_strobe_nxt;
            wr_valid  <= wr_valid_nxt;
            frame_err <= frame_err_nxt;
            cmd_addr  <= cmd_addr_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        rx_shift_nxt  = rx_shift;
        tx_shift_nxt  = tx_shift;
        byte_idx_nxt  = byte_idx;
        armed_nxt     = armed | cs_level;
        miso_nxt      = miso_q;
        rd_strobe_nxt = 1'b0;
        wr_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        cmd_addr_nxt  = cmd_addr;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;

        // A cs rise ends the frame and takes priority over any sck edge in the same cycle.
        if (cs_rise) begin
            state_nxt     = ST_IDLE;
            miso_nxt      = 1'b1;
            bit_cnt_nxt   = '0;
            frame_err_nxt = (state != ST_IDLE) && (bit_cnt[2:0] != 3'd0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed && cs_fall) begin
                        state_nxt    = ST_CMD;
                        bit_cnt_nxt  = '0;
                        rx_shift_nxt = '0;
                        miso_nxt     = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_shift_nxt = rx_word;
                        if (bit_cnt == BYTE_LAST) begin
                            cmd_addr_nxt = rx_word[ADDR_W-1:0];
                            bit_cnt_nxt  = '0;
                            if (rx_word[CMD_RW_BIT]) begin
                                tx_shift_nxt  = sample_in;
                                rd_strobe_nxt = 1'b1;
                                state_nxt     = ST_RD_DATA;
                            end else begin
                                byte_idx_nxt = '0;
                                state_nxt    = ST_WR_DATA;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Counter saturates after the last payload bit; extra clocks read as 1.
                    if (sck_fall) begin
                        if (bit_cnt == LAST_RD_CNT) begin
                            miso_nxt = 1'b1;
                        end else begin
                            miso_nxt     = tx_shift[DATA_BITS-1];
                            tx_shift_nxt = {tx_shift[DATA_BITS-2:0], 1'b1};
                            bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sck_rise) begin
                        rx_shift_nxt = rx_word;
                        if (bit_cnt == BYTE_LAST) begin
                            wr_valid_nxt = 1'b1;
                            wr_data_nxt  = rx_word;
                            wr_addr_nxt  = cmd_addr + byte_idx;
                            byte_idx_nxt = byte_idx + ADDR_W'(1);
                            bit_cnt_nxt  = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule
